// File: rtl/data_sram_resp_pkg.sv
// Shared pipeline definitions: load ops, access-size codes and the
// data-SRAM response FSM encoding.
package data_sram_resp_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'd0,
        LOAD_LH  = 3'd1,
        LOAD_LW  = 3'd2,
        LOAD_LBU = 3'd3,
        LOAD_LHU = 3'd4
    } load_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/data_sram_resp_bytewr_ram.sv
// Word-organised storage with per-byte write enables and a combinational
// read port; one byte-wide array per lane keeps each lane singly driven.
module bytewr_ram
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];

            always_ff @(posedge clk) begin
                if (we && wstrb[gi]) begin
                    mem_q[waddr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = mem_q[raddr];
        end
    endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM request/response front end: accepts one request at a time,
// answers LAT cycles later with a single data_ok pulse.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_wr_q, lat_wr_d;
    logic [ADDR_W-1:0] lat_idx_q, lat_idx_d;
    logic [STRB_W-1:0] lat_wstrb_q, lat_wstrb_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [CNT_W-1:0]  cnt_inc;

    // Size is informational and the byte offset / high address bits alias away.
    logic unused_bits;
    assign unused_bits = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

    assign addr_ok = (state_q != ST_WAIT);
    assign accept  = req && addr_ok;
    assign data_ok = (state_q == ST_RESP);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_wr_d    = lat_wr_q;
        lat_idx_d   = lat_idx_q;
        lat_wstrb_d = lat_wstrb_q;
        lat_wdata_d = lat_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (LAT == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (accept) begin
                    state_d = (LAT == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            cnt_d       = '0;
            lat_wr_d    = wr;
            lat_idx_d   = addr[ADDR_W+1:2];
            lat_wstrb_d = wstrb;
            lat_wdata_d = wdata;
        end
    end

    // A write lands on the edge that ends its RESP cycle, unless reset wins.
    assign ram_we = (state_q == ST_RESP) && lat_wr_q && resetn;

    bytewr_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(lat_idx_q),
        .wstrb(lat_wstrb_q),
        .wdata(lat_wdata_q),
        .raddr(lat_idx_q),
        .rdata(ram_rdata)
    );

    always_comb begin
        rdata = rdata_q;
        if (state_q == ST_RESP) begin
            rdata = lat_wr_q ? '0 : ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            lat_wr_q    <= 1'b0;
            lat_idx_q   <= '0;
            lat_wstrb_q <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_wr_q    <= lat_wr_d;
            lat_idx_q   <= lat_idx_d;
            lat_wstrb_q <= lat_wstrb_d;
            lat_wdata_q <= lat_wdata_d;
            if (state_q == ST_RESP) begin
                rdata_q <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: a LAT=1 instance driven from a vector
// table and a LAT=3 instance exercised by hand-written multi-cycle sequences.
module tb_data_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        resetn1, req1, wr1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  wstrb1;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    logic        resetn3, req3, wr3;
    logic [31:0] addr3, wdata3;
    logic [3:0]  wstrb3;
    logic        addr_ok3, data_ok3;
    logic [31:0] rdata3;

    data_sram_resp #(.ADDR_W(10), .LAT(1)) dut1 (
        .clk(clk), .resetn(resetn1), .req(req1), .wr(wr1), .size(2'd2),
        .addr(addr1), .wstrb(wstrb1), .wdata(wdata1),
        .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
    );

    data_sram_resp #(.ADDR_W(10), .LAT(3)) dut3 (
        .clk(clk), .resetn(resetn3), .req(req3), .wr(wr3), .size(2'd2),
        .addr(addr3), .wstrb(wstrb3), .wdata(wdata3),
        .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // LAT=1: accept on one edge, response in the very next cycle, then idle.
    task automatic txn1(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        req1 = 1'b1; wr1 = w; addr1 = a; wstrb1 = s; wdata1 = d;
        chk("addr_ok1_idle", {31'd0, addr_ok1}, 32'd1);
        @(negedge clk);
        req1 = 1'b0; wr1 = ~w; addr1 = ~a; wstrb1 = ~s; wdata1 = ~d;
        chk("data_ok1_resp", {31'd0, data_ok1}, 32'd1);
        chk("rdata1_resp", rdata1, e);
        @(negedge clk);
        chk("data_ok1_after", {31'd0, data_ok1}, 32'd0);
        chk("rdata1_hold", rdata1, e);
        $display("txn1 %s addr=0x%08h strb=%b wdata=0x%08h rdata=0x%08h",
                 w ? "WR" : "RD", a, s, d, rdata1);
    endtask

    // LAT=3: single request from IDLE, latency measured in cycles.
    task automatic txn3(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] e);
        int n;
        @(negedge clk);
        req3 = 1'b1; wr3 = w; addr3 = a; wstrb3 = s; wdata3 = d;
        chk("addr_ok3_idle", {31'd0, addr_ok3}, 32'd1);
        @(negedge clk);
        req3 = 1'b0; wdata3 = ~d;
        n = 1;
        while (!data_ok3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_latency", n, 32'd3);
        chk("rdata3_resp", rdata3, e);
        @(negedge clk);
        $display("txn3 %s addr=0x%08h strb=%b wdata=0x%08h rdata=0x%08h lat=%0d",
                 w ? "WR" : "RD", a, s, d, rdata3, n);
    endtask

    initial begin
        int          issued, resp_idx, pulses, zeros, cyc, wait_n;
        int          acc_cyc[4];
        logic [31:0] rd_addr[4];
        logic [31:0] rd_exp[4];

        vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF,    32'h1234_5678, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0000_0000, 32'h1234_5678};
        vecs[2]  = '{1'b1, 32'h0000_0100, 4'b0100, 32'h00AB_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0000_0000, 32'h12AB_5678};
        vecs[4]  = '{1'b1, 32'h0000_1000, 4'hF,    32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h0000_0000, 4'h0,    32'h0000_0000, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0100, 4'h0,    32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_F103, 4'h0,    32'h0000_0000, 32'h12AB_5678};
        vecs[8]  = '{1'b1, 32'h0000_0204, 4'hF,    32'h1122_3344, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0204, 4'b0011, 32'h0000_CAFE, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_0204, 4'h0,    32'h0000_0000, 32'h1122_CAFE};
        vecs[11] = '{1'b1, 32'h0000_0204, 4'b1000, 32'h9900_0000, 32'h0000_0000};
        vecs[12] = '{1'b0, 32'h0000_0204, 4'h0,    32'h0000_0000, 32'h9922_CAFE};

        resetn1 = 1'b0; req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wstrb1 = '0; wdata1 = '0;
        resetn3 = 1'b0; req3 = 1'b0; wr3 = 1'b0; addr3 = '0; wstrb3 = '0; wdata3 = '0;

        repeat (2) @(negedge clk);
        chk("rst1_data_ok", {31'd0, data_ok1}, 32'd0);
        chk("rst1_rdata", rdata1, 32'd0);
        chk("rst1_addr_ok", {31'd0, addr_ok1}, 32'd1);
        chk("rst3_data_ok", {31'd0, data_ok3}, 32'd0);
        chk("rst3_rdata", rdata3, 32'd0);
        chk("rst3_addr_ok", {31'd0, addr_ok3}, 32'd1);
        resetn1 = 1'b1; resetn3 = 1'b1;
        @(negedge clk);
        chk("post_rst1_addr_ok", {31'd0, addr_ok1}, 32'd1);
        chk("post_rst3_addr_ok", {31'd0, addr_ok3}, 32'd1);
        $display("reset released");

        for (int i = 0; i < 13; i++) begin
            txn1(vecs[i].wr, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].exp);
        end

        // Back-to-back write then read of 0x40, second accepted during RESP.
        @(negedge clk);
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h40; wstrb1 = 4'hF; wdata1 = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("b2b_wr_data_ok", {31'd0, data_ok1}, 32'd1);
        chk("b2b_wr_rdata", rdata1, 32'd0);
        chk("b2b_addr_ok_resp", {31'd0, addr_ok1}, 32'd1);
        wr1 = 1'b0; addr1 = 32'h40; wstrb1 = 4'h0; wdata1 = 32'h0;
        @(negedge clk);
        req1 = 1'b0;
        chk("b2b_rd_data_ok", {31'd0, data_ok1}, 32'd1);
        chk("b2b_rd_rdata", rdata1, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("b2b_idle_data_ok", {31'd0, data_ok1}, 32'd0);
        $display("b2b WR/RD addr=0x00000040 rdata=0x%08h", rdata1);

        // LAT=3 preload for the held-request burst.
        for (int k = 0; k < 4; k++) begin
            rd_addr[k] = 32'(k * 4);
            rd_exp[k]  = 32'hC0DE_0000 + 32'(k * 32'h111);
            txn3(1'b1, rd_addr[k], 4'hF, rd_exp[k], 32'h0);
        end

        // Four reads with req held high.
        issued = 0; resp_idx = 0; pulses = 0; zeros = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (data_ok3) begin
                pulses++;
                if (resp_idx < 4) begin
                    chk("burst_rdata", rdata3, rd_exp[resp_idx]);
                    chk("burst_latency", cyc - acc_cyc[resp_idx], 32'd3);
                    $display("burst resp %0d rdata=0x%08h", resp_idx, rdata3);
                end
                resp_idx++;
            end
            if (issued < 4) begin
                req3 = 1'b1; wr3 = 1'b0; addr3 = rd_addr[issued]; wstrb3 = 4'h0;
                if (addr_ok3) begin
                    if (issued > 0) chk("burst_addr_ok_low", zeros, 32'd2);
                    acc_cyc[issued] = cyc;
                    zeros = 0;
                    issued++;
                end else begin
                    zeros++;
                end
            end else begin
                req3 = 1'b0;
            end
        end
        chk("burst_pulses", pulses, 32'd4);
        chk("burst_issued", issued, 32'd4);

        // Reset during an in-flight write must drop it.
        txn3(1'b1, 32'h20, 4'hF, 32'h0BAD_F00D, 32'h0);
        @(negedge clk);
        req3 = 1'b1; wr3 = 1'b1; addr3 = 32'h20; wstrb3 = 4'hF; wdata3 = 32'h5555_5555;
        @(negedge clk);
        req3 = 1'b0; resetn3 = 1'b0;
        @(negedge clk);
        chk("rstmid_data_ok", {31'd0, data_ok3}, 32'd0);
        chk("rstmid_rdata", rdata3, 32'd0);
        chk("rstmid_addr_ok", {31'd0, addr_ok3}, 32'd1);
        resetn3 = 1'b1;
        wait_n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (data_ok3) wait_n++;
        end
        chk("rstmid_no_data_ok", wait_n, 32'd0);
        $display("reset mid-flight, stray pulses=%0d", wait_n);
        txn3(1'b0, 32'h20, 4'h0, 32'h0, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
